// File: rtl/svm_pkg.sv
// Shared definitions for the support-vector memory responder.
// Holds the FSM state encoding, default parameter values and a width helper.
package svm_pkg;

  localparam int XLEN_PIXEL_DEF    = 8;
  localparam int NUM_OF_PIXELS_DEF = 4;
  localparam int NUM_OF_SV_DEF     = 10;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    READY = 2'd1,
    READ  = 2'd2
  } state_t;

  // Index width that stays at least one bit when a dimension is 1.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sv_mem_resp_sv_ram.sv
// sv_ram: simple dual-port storage for {sv1, sv2} pairs.
// Synchronous write, registered read; the read register holds its value when
// no read is requested, and it is the only part cleared by reset.
//   clk   - clock
//   rst   - asynchronous active-low reset (read register only)
//   we    - write enable, waddr/wdata
//   re    - read enable, raddr; rdata valid the cycle after re
module sv_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 40,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sv_mem_resp.sv
// sv_mem_resp: loads NUM_OF_SV x NUM_OF_PIXELS support-vector pairs plus one
// row of test pixels, then streams them back entry by entry on request.
//   clk, rst (async active-low)
//   we, re, flush               - controller strobes
//   sv_in1, sv_in2, x_in        - load data
//   sv_out1, sv_out2, x_out     - registered read data
//   rd_valid, sv_idx, pix_idx   - read data qualifier and position
//   load_done, rd_done, err_ovf - status (level, last-entry pulse, sticky)
module sv_mem_resp
  import svm_pkg::*;
#(
  parameter int XLEN_PIXEL    = XLEN_PIXEL_DEF,
  parameter int NUM_OF_PIXELS = NUM_OF_PIXELS_DEF,
  parameter int NUM_OF_SV     = NUM_OF_SV_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  we,
  input  logic                                  re,
  input  logic                                  flush,
  input  logic [XLEN_PIXEL-1:0]                 sv_in1,
  input  logic [XLEN_PIXEL-1:0]                 sv_in2,
  input  logic [XLEN_PIXEL-1:0]                 x_in,
  output logic [XLEN_PIXEL-1:0]                 sv_out1,
  output logic [XLEN_PIXEL-1:0]                 sv_out2,
  output logic [XLEN_PIXEL-1:0]                 x_out,
  output logic                                  rd_valid,
  output logic [clog2_min1(NUM_OF_SV)-1:0]      sv_idx,
  output logic [clog2_min1(NUM_OF_PIXELS)-1:0]  pix_idx,
  output logic                                  load_done,
  output logic                                  rd_done,
  output logic                                  err_ovf
);

  localparam int DEPTH = NUM_OF_SV * NUM_OF_PIXELS;
  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int SV_W  = clog2_min1(NUM_OF_SV);
  localparam int PIX_W = clog2_min1(NUM_OF_PIXELS);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_OF_PIXELS - 1);
  localparam logic [PTR_W:0]   NPIX_EXT = (PTR_W + 1)'(NUM_OF_PIXELS);

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [SV_W-1:0]   rd_sv;
  logic [PIX_W-1:0]  rd_pix;
  logic              do_write, do_read, ovf_set;
  logic              wr_last, rd_last, x_slot;
  logic [2*XLEN_PIXEL-1:0] ram_rdata;
  logic [XLEN_PIXEL-1:0]   x_mem [NUM_OF_PIXELS];

  assign wr_last = (wr_ptr == LAST_PTR);
  assign rd_last = (rd_ptr == LAST_PTR);
  assign x_slot  = ({1'b0, wr_ptr} < NPIX_EXT);

  // A read request in READY already fetches entry 0, so a pass of DEPTH
  // consecutive re cycles yields DEPTH valid outputs.
  always_comb begin
    state_d  = state_q;
    do_write = 1'b0;
    do_read  = 1'b0;
    ovf_set  = 1'b0;
    if (flush) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD: begin
          if (we) begin
            do_write = 1'b1;
            if (wr_last) state_d = READY;
          end
        end
        READY, READ: begin
          ovf_set = we;
          if (re) begin
            do_read = 1'b1;
            state_d = rd_last ? READY : READ;
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= LOAD;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_sv     <= '0;
      rd_pix    <= '0;
      load_done <= 1'b0;
      err_ovf   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_done   <= 1'b0;
      sv_idx    <= '0;
      pix_idx   <= '0;
      x_out     <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        rd_sv     <= '0;
        rd_pix    <= '0;
        load_done <= 1'b0;
        err_ovf   <= 1'b0;
        rd_valid  <= 1'b0;
        rd_done   <= 1'b0;
      end else begin
        rd_valid <= do_read;
        rd_done  <= do_read && rd_last;
        if (ovf_set) err_ovf <= 1'b1;
        if (do_write) begin
          wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;
          if (wr_last) load_done <= 1'b1;
        end
        if (do_read) begin
          sv_idx  <= rd_sv;
          pix_idx <= rd_pix;
          x_out   <= x_mem[rd_pix];
          // sv/pixel counters run alongside rd_ptr to avoid a divider.
          if (rd_last) begin
            rd_ptr <= '0;
            rd_sv  <= '0;
            rd_pix <= '0;
          end else begin
            rd_ptr <= rd_ptr + 1'b1;
            if (rd_pix == LAST_PIX) begin
              rd_pix <= '0;
              rd_sv  <= rd_sv + 1'b1;
            end else begin
              rd_pix <= rd_pix + 1'b1;
            end
          end
        end
      end
    end
  end

  // Only the first row of writes carries a test pixel.
  always_ff @(posedge clk) begin
    if (do_write && x_slot) x_mem[wr_ptr[PIX_W-1:0]] <= x_in;
  end

  sv_ram #(
    .DATA_W (2 * XLEN_PIXEL),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_sv_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (do_write),
    .waddr (wr_ptr),
    .wdata ({sv_in1, sv_in2}),
    .re    (do_read),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  assign {sv_out1, sv_out2} = ram_rdata;

endmodule

// File: tb/tb_sv_mem_resp.sv
module tb_sv_mem_resp;

  localparam int XW    = 8;
  localparam int NP    = 4;
  localparam int NSV   = 10;
  localparam int DEPTH = NP * NSV;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we = 1'b0, re = 1'b0, flush = 1'b0;
  logic [XW-1:0] sv_in1 = '0, sv_in2 = '0, x_in = '0;
  logic [XW-1:0] sv_out1, sv_out2, x_out;
  logic          rd_valid, load_done, rd_done, err_ovf;
  logic [3:0]    sv_idx;
  logic [1:0]    pix_idx;

  int checks = 0;
  int failures = 0;

  // Reference contents of the memory as the controller intends them.
  logic [XW-1:0] ref_sv1 [DEPTH];
  logic [XW-1:0] ref_sv2 [DEPTH];
  logic [XW-1:0] ref_x   [NP];

  sv_mem_resp #(.XLEN_PIXEL(XW), .NUM_OF_PIXELS(NP), .NUM_OF_SV(NSV)) dut (
    .clk(clk), .rst(rst), .we(we), .re(re), .flush(flush),
    .sv_in1(sv_in1), .sv_in2(sv_in2), .x_in(x_in),
    .sv_out1(sv_out1), .sv_out2(sv_out2), .x_out(x_out),
    .rd_valid(rd_valid), .sv_idx(sv_idx), .pix_idx(pix_idx),
    .load_done(load_done), .rd_done(rd_done), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // All outputs packed for one-shot comparison.
  function automatic logic [36:0] outs();
    return {sv_out1, sv_out2, x_out, rd_valid, sv_idx, pix_idx, load_done, rd_done, err_ovf};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    checks++;
    if (outs() !== 37'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", outs());
    end
    rst = 1'b1;
    step();
  endtask

  // Full load; pattern=1 uses sv1=k, sv2=3k, x=10+k, otherwise random data.
  task automatic test_load(input bit pattern);
    for (int k = 0; k < DEPTH; k++) begin
      we = 1'b1;
      re = 1'($urandom_range(0, 1));
      sv_in1 = pattern ? XW'(k) : XW'($urandom);
      sv_in2 = pattern ? XW'((3 * k) % 256) : XW'($urandom);
      x_in   = pattern ? XW'(10 + k) : XW'($urandom);
      ref_sv1[k] = sv_in1;
      ref_sv2[k] = sv_in2;
      if (k < NP) ref_x[k] = x_in;
      step();
      checks++;
      if (rd_valid !== 1'b0) begin
        failures++;
        $display("FAIL load_no_read k=%0d rd_valid got=%b exp=0", k, rd_valid);
      end
      checks++;
      if (load_done !== (k == DEPTH - 1)) begin
        failures++;
        $display("FAIL load_done k=%0d got=%b exp=%b", k, load_done, (k == DEPTH - 1));
      end
    end
    we = 1'b0;
    re = 1'b0;
  endtask

  // One read pass; pauses of pause_len cycles at entry pause_at, plus random
  // gaps when rnd is set. Held data is checked during pauses.
  task automatic test_read_pass(input int pause_at, input int pause_len, input bit rnd,
                                input logic exp_ovf);
    int k = 0;
    int paused = 0;
    int cyc = 0;
    bit re_now;
    logic [36:0] exp;
    logic [XW-1:0] h1 = '0, h2 = '0, hx = '0;
    logic [3:0] hs = '0;
    logic [1:0] hp = '0;
    while (k < DEPTH && cyc < 8 * DEPTH) begin
      cyc++;
      if (k == pause_at && paused < pause_len) begin
        re_now = 1'b0;
        paused++;
      end else if (rnd) begin
        re_now = ($urandom_range(0, 3) != 0);
      end else begin
        re_now = 1'b1;
      end
      re = re_now;
      step();
      if (re_now) begin
        h1 = ref_sv1[k]; h2 = ref_sv2[k]; hx = ref_x[k % NP];
        hs = 4'(k / NP); hp = 2'(k % NP);
        exp = {h1, h2, hx, 1'b1, hs, hp, 1'b1, (k == DEPTH - 1), exp_ovf};
        checks++;
        if (outs() !== exp) begin
          failures++;
          $display("FAIL read_entry k=%0d got=%h exp=%h", k, outs(), exp);
        end
        k++;
      end else if (k > 0) begin
        exp = {h1, h2, hx, 1'b0, hs, hp, 1'b1, 1'b0, exp_ovf};
        checks++;
        if (outs() !== exp) begin
          failures++;
          $display("FAIL read_pause k=%0d got=%h exp=%h", k, outs(), exp);
        end
      end
    end
    checks++;
    if (k != DEPTH) begin
      failures++;
      $display("FAIL read_timeout entries got=%0d exp=%0d", k, DEPTH);
    end
    re = 1'b0;
    step();
    checks++;
    if ({rd_valid, rd_done, load_done} !== 3'b001) begin
      failures++;
      $display("FAIL read_end valid/done/load got=%b exp=001", {rd_valid, rd_done, load_done});
    end
  endtask

  task automatic test_overflow();
    we = 1'b1;
    sv_in1 = 8'hFF;
    sv_in2 = 8'hFF;
    x_in = 8'hFF;
    step();
    we = 1'b0;
    checks++;
    if (err_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set got=%b exp=1", err_ovf);
    end
    repeat (3) step();
    checks++;
    if (err_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky got=%b exp=1", err_ovf);
    end
    test_read_pass(-1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midload();
    for (int k = 0; k < 20; k++) begin
      we = 1'b1;
      sv_in1 = XW'($urandom);
      sv_in2 = XW'($urandom);
      x_in = XW'($urandom);
      step();
    end
    // Reset asserted during write 20, before its clock edge.
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (outs() !== 37'd0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", outs());
    end
    we = 1'b0;
    step();
    rst = 1'b1;
    step();
    test_load(1'b0);
    test_read_pass(-1, 0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    re = 1'b1;
    repeat (5) step();
    we = 1'b1;
    step();
    checks++;
    if (err_ovf !== 1'b1) begin
      failures++;
      $display("FAIL flush_pre_ovf got=%b exp=1", err_ovf);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    we = 1'b0;
    re = 1'b0;
    checks++;
    if ({load_done, rd_valid, rd_done, err_ovf} !== 4'b0000) begin
      failures++;
      $display("FAIL flush_clear got=%b exp=0000", {load_done, rd_valid, rd_done, err_ovf});
    end
    step();
    checks++;
    if ({load_done, rd_valid} !== 2'b00) begin
      failures++;
      $display("FAIL flush_in_load got=%b exp=00", {load_done, rd_valid});
    end
    test_load(1'b1);
    test_read_pass(-1, 0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_load(1'b1);
    checks++;
    if (err_ovf !== 1'b0) begin
      failures++;
      $display("FAIL load_no_ovf got=%b exp=0", err_ovf);
    end
    test_read_pass(-1, 0, 1'b0, 1'b0);
    test_read_pass(17, 3, 1'b0, 1'b0);
    test_overflow();
    test_reset_midload();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
